axil_cmd_master: RTL and testbench

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_master_pkg.sv | 18 +
 rtl/axil_cmd_master.sv | 182 ++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_master_pkg.sv
// Shared types and constants for the single-outstanding AXI4-Lite command master.
package axil_master_pkg;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WAIT_B  = 3'd2,
    RD_AR   = 3'd3,
    WAIT_R  = 3'd4,
    DONE    = 3'd5
  } state_e;

  // AXI response codes of interest
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : axil_master_pkg

// File: rtl/axil_cmd_master.sv
// Converts single local read/write commands into AXI4-Lite transactions,
// one outstanding at a time, and reports completion with a one-cycle pulse.
module axil_cmd_master
  import axil_master_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  // write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  // write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  // write response channel
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  // read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY,
  // local command side
  input  logic                              CMD_VALID,
  output logic                              CMD_READY,
  input  logic                              CMD_WRITE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_WDATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   CMD_WSTRB,
  // completion side
  output logic                              RSP_VALID,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     RSP_RDATA,
  output logic [1:0]                        RSP_RESP
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;

  // State and registered outputs; reset aborts any transaction and clears payloads
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Next-state and next-output logic; per-state flags derive from the next state
  // so every output is registered and lines up with the state it belongs to
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          addr_d  = CMD_ADDR;
          wdata_d = CMD_WDATA;
          wstrb_d = CMD_WSTRB;
          if (CMD_WRITE) begin
            state_d   = WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        // AW and W complete independently; leave once both have handshaken
        awvalid_d = awvalid_q && !M_AXI_AWREADY;
        wvalid_d  = wvalid_q && !M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (M_AXI_BVALID && bready_q) begin
          rsp_resp_d  = M_AXI_BRESP;
          rsp_rdata_d = '0;
          state_d     = DONE;
        end
      end
      RD_AR: begin
        if (M_AXI_ARREADY && arvalid_q) begin
          arvalid_d = 1'b0;
          state_d   = WAIT_R;
        end
      end
      WAIT_R: begin
        if (M_AXI_RVALID && rready_q) begin
          rsp_resp_d  = M_AXI_RRESP;
          rsp_rdata_d = M_AXI_RDATA;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bready_d    = (state_d == WAIT_B);
    rready_d    = (state_d == WAIT_R);
    rsp_valid_d = (state_d == DONE);
    cmd_ready_d = (state_d == IDLE);
  end

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign CMD_READY     = cmd_ready_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_RDATA     = rsp_rdata_q;
  assign RSP_RESP      = rsp_resp_q;

endmodule : axil_cmd_master

// File: tb/tb_axil_cmd_master.sv
// Scoreboard bench: stimulus pushes expected completions computed from a
// word-array memory model; a monitor pops them on RSP_VALID. A behavioural
// AXI-Lite slave with per-transaction delays checks the bus side.
module tb_axil_cmd_master;
  import axil_master_pkg::*;

  localparam logic [31:0] BASE = 32'h70E0_0000;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_d;
    int          w_d;
    int          b_d;
    int          ar_d;
    int          r_d;
    logic [1:0]  resp;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  logic        M_AXI_ACLK = 1'b0;
  logic        M_AXI_ARESETN = 1'b0;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY = 1'b0;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_RDATA = 32'h0;
  logic [1:0]  M_AXI_RRESP = 2'b00;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WRITE = 1'b0;
  logic [31:0] CMD_ADDR = 32'h0;
  logic [31:0] CMD_WDATA = 32'h0;
  logic [3:0]  CMD_WSTRB = 4'h0;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;

  axil_cmd_master #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) dut (
    .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESETN(M_AXI_ARESETN),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR),
    .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP)
  );

  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  logic [140:0] all_outs;
  assign all_outs = {M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
                     M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY, CMD_READY,
                     RSP_VALID, RSP_RDATA, RSP_RESP};

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_rsp = 0;
  int          n_ar_hs = 0;
  int          last_ar_cyc = 0;
  plan_t       plan_q[$];
  exp_t        exp_q[$];
  logic [31:0] model_mem [8];
  logic [31:0] slave_mem [8];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Behavioural slave: decides READY/VALID at negedges, so a handshake decided
  // here happens at the following rising edge and is committed one negedge later
  initial begin : slave
    plan_t       cur;
    bit          active, aw_pend, w_pend, ar_pend, b_pend, r_pend, aw_done, w_done, ar_done;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, ar_cyc;
    logic [31:0] aw_bus, w_bus, ar_bus;
    logic [3:0]  s_bus;
    active = 0;
    forever begin
      @(negedge M_AXI_ACLK);
      if (!M_AXI_ARESETN) begin
        active = 0; aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        M_AXI_BVALID = 0; M_AXI_RVALID = 0;
      end else begin
        if (aw_pend) begin
          aw_pend = 0; aw_done = 1; M_AXI_AWREADY = 0;
          chk(!M_AXI_AWVALID, "awvalid_drop", 64'(M_AXI_AWVALID), 0);
        end
        if (w_pend) begin
          w_pend = 0; w_done = 1; M_AXI_WREADY = 0;
          chk(!M_AXI_WVALID, "wvalid_drop", 64'(M_AXI_WVALID), 0);
        end
        if (ar_pend) begin
          ar_pend = 0; ar_done = 1; M_AXI_ARREADY = 0; n_ar_hs++;
          chk(!M_AXI_ARVALID, "arvalid_drop", 64'(M_AXI_ARVALID), 0);
        end
        if (b_pend) begin
          b_pend = 0; M_AXI_BVALID = 0; active = 0;
          if (cur.resp == RESP_OKAY)
            for (int b = 0; b < 4; b++)
              if (s_bus[b]) slave_mem[aw_bus[4:2]][8*b +: 8] = w_bus[8*b +: 8];
        end
        if (r_pend) begin
          r_pend = 0; M_AXI_RVALID = 0; active = 0;
        end
        if (!active && (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID)) begin
          if (plan_q.size() == 0) begin
            chk(0, "bus_without_cmd", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}), 0);
          end else begin
            cur = plan_q.pop_front();
            active = 1; aw_done = 0; w_done = 0; ar_done = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; ar_cyc = 0;
            chk({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID} == (cur.write ? 3'b110 : 3'b001),
                "valid_start", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}),
                cur.write ? 64'h6 : 64'h1);
          end
        end
        if (active && cur.write) begin
          if (!aw_done && !aw_pend) begin
            chk(M_AXI_AWVALID && M_AXI_AWADDR == cur.addr, "aw_hold",
                {31'h0, M_AXI_AWVALID, M_AXI_AWADDR}, {32'h1, cur.addr});
            if (aw_cnt >= cur.aw_d) begin
              M_AXI_AWREADY = 1; aw_pend = 1; aw_bus = M_AXI_AWADDR;
            end else aw_cnt++;
          end
          if (!w_done && !w_pend) begin
            chk(M_AXI_WVALID && M_AXI_WDATA == cur.wdata && M_AXI_WSTRB == cur.wstrb, "w_hold",
                {27'h0, M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WDATA}, {28'h1, cur.wstrb, cur.wdata});
            if (w_cnt >= cur.w_d) begin
              M_AXI_WREADY = 1; w_pend = 1; w_bus = M_AXI_WDATA; s_bus = M_AXI_WSTRB;
            end else w_cnt++;
          end
          chk(!M_AXI_BREADY || (aw_done && w_done), "bready_early", 64'(M_AXI_BREADY), 0);
          if (aw_done && w_done && !b_pend) begin
            if (!M_AXI_BVALID) begin
              if (b_cnt >= cur.b_d) begin M_AXI_BVALID = 1; M_AXI_BRESP = cur.resp; end
              else b_cnt++;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) b_pend = 1;
          end
        end else if (active) begin
          if (!ar_done && !ar_pend) begin
            chk(M_AXI_ARVALID && M_AXI_ARADDR == cur.addr, "ar_hold",
                {31'h0, M_AXI_ARVALID, M_AXI_ARADDR}, {32'h1, cur.addr});
            ar_cyc++;
            if (ar_cnt >= cur.ar_d) begin
              M_AXI_ARREADY = 1; ar_pend = 1; ar_bus = M_AXI_ARADDR; last_ar_cyc = ar_cyc;
            end else ar_cnt++;
          end
          chk(!M_AXI_RREADY || ar_done, "rready_early", 64'(M_AXI_RREADY), 0);
          if (ar_done && !r_pend) begin
            if (!M_AXI_RVALID) begin
              if (r_cnt >= cur.r_d) begin
                M_AXI_RVALID = 1; M_AXI_RDATA = slave_mem[ar_bus[4:2]]; M_AXI_RRESP = cur.resp;
              end else r_cnt++;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) r_pend = 1;
          end
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard on every RSP_VALID
  initial begin : monitor
    bit   prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge M_AXI_ACLK);
      if (M_AXI_ARESETN && RSP_VALID) begin
        chk(!prev, "rsp_single_pulse", 64'(prev), 0);
        n_rsp++;
        if (exp_q.size() == 0) begin
          chk(0, "rsp_unexpected", 64'(RSP_RDATA), 0);
        end else begin
          e = exp_q.pop_front();
          chk(RSP_RDATA == e.rdata, "rsp_rdata", 64'(RSP_RDATA), 64'(e.rdata));
          chk(RSP_RESP == e.resp, "rsp_resp", 64'(RSP_RESP), 64'(e.resp));
        end
      end
      prev = M_AXI_ARESETN && RSP_VALID;
    end
  end

  function automatic plan_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int aw_d, input int w_d,
                               input int br_d, input logic [1:0] resp);
    plan_t p;
    p.write = wr; p.addr = addr; p.wdata = wdata; p.wstrb = wstrb;
    p.aw_d = aw_d; p.w_d = w_d; p.ar_d = aw_d; p.b_d = br_d; p.r_d = br_d; p.resp = resp;
    return p;
  endfunction

  function automatic exp_t model(input plan_t p);
    exp_t        e;
    logic [2:0]  idx;
    idx = p.addr[4:2];
    e.resp = p.resp;
    if (p.write) begin
      e.rdata = 32'h0;
      if (p.resp == RESP_OKAY)
        for (int b = 0; b < 4; b++)
          if (p.wstrb[b]) model_mem[idx][8*b +: 8] = p.wdata[8*b +: 8];
    end else begin
      e.rdata = model_mem[idx];
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after acceptance
  task automatic issue(input plan_t p, input bit expect_rsp);
    int n;
    plan_q.push_back(p);
    if (expect_rsp) exp_q.push_back(model(p));
    CMD_WRITE = p.write; CMD_ADDR = p.addr; CMD_WDATA = p.wdata; CMD_WSTRB = p.wstrb;
    CMD_VALID = 1;
    n = 0;
    while (!CMD_READY && n < 200) begin @(negedge M_AXI_ACLK); n++; end
    chk(CMD_READY, "accept_timeout", 64'(CMD_READY), 1);
    @(negedge M_AXI_ACLK);
    CMD_VALID = 0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (n_rsp < target && n < 300) begin @(negedge M_AXI_ACLK); n++; end
    chk(n_rsp >= target, "rsp_timeout", 64'(n_rsp), 64'(target));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    plan_t p;
    int    tgt, acc, ar0, r0, n;
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = 32'hA5A5_0000 + 32'(i);
      slave_mem[i] = 32'hA5A5_0000 + 32'(i);
    end
    model_mem[0] = 32'h1234_5678;
    slave_mem[0] = 32'h1234_5678;
    tgt = 0;

    // reset values and release timing
    repeat (3) @(negedge M_AXI_ACLK);
    chk(all_outs == '0, "reset_outputs_zero", 64'(|all_outs), 0);
    M_AXI_ARESETN = 1;
    #1 chk(!CMD_READY, "cmd_ready_before_edge", 64'(CMD_READY), 0);
    @(negedge M_AXI_ACLK);
    chk(CMD_READY, "cmd_ready_after_release", 64'(CMD_READY), 1);

    // zero-wait write with cycle-exact timing
    issue(mk(1, 32'h70E0_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, RESP_OKAY), 1);
    chk(M_AXI_AWVALID && M_AXI_WVALID, "c1_aw_w_valid", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 3);
    @(negedge M_AXI_ACLK);
    chk({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} == 3'b001, "c2_wait_b",
        64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 1);
    @(negedge M_AXI_ACLK);
    chk({RSP_VALID, CMD_READY} == 2'b10, "c3_rsp_valid", 64'({RSP_VALID, CMD_READY}), 2);
    @(negedge M_AXI_ACLK);
    chk({RSP_VALID, CMD_READY} == 2'b01, "c4_cmd_ready", 64'({RSP_VALID, CMD_READY}), 1);
    tgt++; wait_done(tgt);

    // read with ARREADY delayed 3 cycles
    issue(mk(0, 32'h70E0_0000, 32'h0, 4'h0, 3, 0, 0, RESP_OKAY), 1);
    tgt++; wait_done(tgt);
    chk(last_ar_cyc == 4, "arvalid_cycles", 64'(last_ar_cyc), 4);

    // W before AW, then AW before W
    issue(mk(1, BASE + 32'h8, 32'h0BAD_F00D, 4'h5, 2, 0, 1, RESP_OKAY), 1);
    tgt++; wait_done(tgt);
    p = mk(1, BASE + 32'hC, 32'hCAFE_1234, 4'hA, 0, 2, 0, RESP_OKAY);
    issue(p, 1);
    tgt++; wait_done(tgt);

    // error response passthrough, then a normal read of the written word
    issue(mk(0, BASE + 32'h8, 32'h0, 4'h0, 1, 0, 2, RESP_SLVERR), 1);
    tgt++; wait_done(tgt);
    issue(mk(0, BASE + 32'h4, 32'h0, 4'h0, 0, 0, 0, RESP_OKAY), 1);
    tgt++; wait_done(tgt);

    // randomized traffic
    repeat (40) begin
      p = mk($urandom_range(0, 1) == 1, BASE + (32'($urandom_range(0, 7)) << 2), $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY);
      p.ar_d = $urandom_range(0, 3);
      p.r_d  = $urandom_range(0, 3);
      issue(p, 1);
      tgt++; wait_done(tgt);
      repeat ($urandom_range(0, 2)) @(negedge M_AXI_ACLK);
    end

    // CMD_VALID held high: one zero-wait read per 4 cycles
    p = mk(0, BASE + 32'h10, 32'h0, 4'h0, 0, 0, 0, RESP_OKAY);
    n = 0;
    while (!CMD_READY && n < 50) begin @(negedge M_AXI_ACLK); n++; end
    CMD_WRITE = 0; CMD_ADDR = p.addr; CMD_VALID = 1;
    acc = 0; ar0 = n_ar_hs; r0 = n_rsp;
    for (int i = 0; i < 40; i++) begin
      if (CMD_READY) begin acc++; plan_q.push_back(p); exp_q.push_back(model(p)); end
      @(negedge M_AXI_ACLK);
    end
    CMD_VALID = 0;
    wait_done(r0 + acc);
    tgt = r0 + acc;
    chk(acc == 10, "held_valid_accepts", 64'(acc), 10);
    chk(n_ar_hs - ar0 == 10, "held_valid_ar_count", 64'(n_ar_hs - ar0), 10);

    // reset in WAIT_B aborts without a completion
    issue(mk(1, BASE + 32'h18, 32'h5555_AAAA, 4'hF, 0, 0, 30, RESP_OKAY), 0);
    n = 0;
    while (!M_AXI_BREADY && n < 50) begin @(negedge M_AXI_ACLK); n++; end
    chk(M_AXI_BREADY, "reached_wait_b", 64'(M_AXI_BREADY), 1);
    r0 = n_rsp;
    #2 M_AXI_ARESETN = 0;
    #1 chk(all_outs == '0, "abort_outputs_zero", 64'(|all_outs), 0);
    repeat (3) @(negedge M_AXI_ACLK);
    M_AXI_ARESETN = 1;
    #1 chk(!CMD_READY, "abort_ready_before_edge", 64'(CMD_READY), 0);
    @(negedge M_AXI_ACLK);
    chk(CMD_READY, "abort_ready_after_edge", 64'(CMD_READY), 1);
    chk(n_rsp == r0, "abort_no_rsp", 64'(n_rsp), 64'(r0));

    // aborted write must not have reached memory
    issue(mk(0, BASE + 32'h18, 32'h0, 4'h0, 0, 0, 0, RESP_OKAY), 1);
    tgt = n_rsp + 1; wait_done(tgt);

    repeat (5) @(negedge M_AXI_ACLK);
    chk(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 0);
    chk(plan_q.size() == 0, "plans_consumed", 64'(plan_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_axil_cmd_master
